// File: rtl/tap_bram_arbiter.sv
// Two-requester (config / FIR engine) arbiter for the single-port tap RAM.
// Round-robin grant, range checking, and a two-stage read-return pipeline.
module tap_bram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned DEPTH      = 11
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  cfg_req,
    input  logic [3:0]            cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [BIT_WIDTH-1:0]  cfg_wdata,
    output logic                  cfg_gnt,
    output logic                  cfg_rvalid,
    output logic [BIT_WIDTH-1:0]  cfg_rdata,
    output logic                  cfg_err,

    input  logic                  eng_req,
    input  logic [3:0]            eng_we,
    input  logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic [BIT_WIDTH-1:0]  eng_wdata,
    output logic                  eng_gnt,
    output logic                  eng_rvalid,
    output logic [BIT_WIDTH-1:0]  eng_rdata,
    output logic                  eng_err,

    input  logic                  eng_busy,

    output logic [3:0]            bram_WE,
    output logic                  bram_EN,
    output logic [BIT_WIDTH-1:0]  bram_Di,
    output logic [ADDR_WIDTH-1:0] bram_A,
    input  logic [BIT_WIDTH-1:0]  bram_Do
);

    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
    localparam logic [WORD_AW-1:0] DEPTH_W = WORD_AW'(DEPTH);

    typedef enum logic {
        OWN_CFG = 1'b0,
        OWN_ENG = 1'b1
    } owner_t;

    owner_t                  last_gnt;

    // Stage 1: command granted last cycle that still owes a response
    logic                    s1_valid;
    owner_t                  s1_owner;
    logic                    s1_read;
    logic                    s1_oor;

    logic                    cfg_rvalid_q;
    logic                    cfg_err_q;
    logic [BIT_WIDTH-1:0]    cfg_rdata_q;
    logic                    eng_rvalid_q;
    logic                    eng_err_q;
    logic [BIT_WIDTH-1:0]    eng_rdata_q;

    logic                    cfg_elig;
    logic                    eng_elig;
    logic                    pick_eng;
    logic                    any_gnt;
    logic [3:0]              sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [BIT_WIDTH-1:0]    sel_wdata;
    logic                    sel_inrange;
    logic                    rd_pend;

    // Eligibility, round-robin choice and command mux
    always_comb begin
        cfg_elig    = cfg_req && !((cfg_we != 4'd0) && eng_busy);
        eng_elig    = eng_req;
        pick_eng    = eng_elig && (!cfg_elig || (last_gnt == OWN_CFG));
        any_gnt     = !RST && (cfg_elig || eng_elig);
        cfg_gnt     = any_gnt && !pick_eng;
        eng_gnt     = any_gnt && pick_eng;
        sel_we      = pick_eng ? eng_we    : cfg_we;
        sel_addr    = pick_eng ? eng_addr  : cfg_addr;
        sel_wdata   = pick_eng ? eng_wdata : cfg_wdata;
        sel_inrange = (sel_addr[1:0] == 2'b00) && (sel_addr[ADDR_WIDTH-1:2] < DEPTH_W);
        rd_pend     = s1_valid && s1_read && !s1_oor;
    end

    // BRAM port drive; a read from last cycle keeps EN high so Do stays valid
    always_comb begin
        bram_EN = 1'b0;
        bram_WE = 4'd0;
        bram_A  = '0;
        bram_Di = '0;
        if (any_gnt && sel_inrange) begin
            bram_EN = 1'b1;
            bram_WE = sel_we;
            bram_A  = sel_addr;
            bram_Di = sel_wdata;
        end else if (rd_pend && !RST) begin
            bram_EN = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_gnt     <= OWN_ENG;
            s1_valid     <= 1'b0;
            s1_owner     <= OWN_CFG;
            s1_read      <= 1'b0;
            s1_oor       <= 1'b0;
            cfg_rvalid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_rdata_q  <= '0;
            eng_rvalid_q <= 1'b0;
            eng_err_q    <= 1'b0;
            eng_rdata_q  <= '0;
        end else begin
            if (any_gnt) begin
                last_gnt <= pick_eng ? OWN_ENG : OWN_CFG;
            end
            s1_valid <= any_gnt && ((sel_we == 4'd0) || !sel_inrange);
            s1_owner <= pick_eng ? OWN_ENG : OWN_CFG;
            s1_read  <= (sel_we == 4'd0);
            s1_oor   <= !sel_inrange;

            cfg_rvalid_q <= s1_valid && s1_read && (s1_owner == OWN_CFG);
            eng_rvalid_q <= s1_valid && s1_read && (s1_owner == OWN_ENG);
            cfg_err_q    <= s1_valid && s1_oor && (s1_owner == OWN_CFG);
            eng_err_q    <= s1_valid && s1_oor && (s1_owner == OWN_ENG);

            // Out-of-range reads return zero data alongside the error
            if (s1_valid && s1_read && (s1_owner == OWN_CFG)) begin
                cfg_rdata_q <= s1_oor ? '0 : bram_Do;
            end
            if (s1_valid && s1_read && (s1_owner == OWN_ENG)) begin
                eng_rdata_q <= s1_oor ? '0 : bram_Do;
            end
        end
    end

    // Responses read as zero for the whole reset window, including its first cycle
    always_comb begin
        cfg_rvalid = cfg_rvalid_q && !RST;
        cfg_err    = cfg_err_q && !RST;
        cfg_rdata  = RST ? '0 : cfg_rdata_q;
        eng_rvalid = eng_rvalid_q && !RST;
        eng_err    = eng_err_q && !RST;
        eng_rdata  = RST ? '0 : eng_rdata_q;
    end

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// Directed bench for tap_bram_arbiter with a behavioural tap RAM
// (registered address, byte writes, Do gated by EN).
module tb_tap_bram_arbiter;

    logic        CLK;
    logic        RST;
    logic        cfg_req, eng_req, eng_busy;
    logic [3:0]  cfg_we, eng_we;
    logic [11:0] cfg_addr, eng_addr;
    logic [31:0] cfg_wdata, eng_wdata;
    logic        cfg_gnt, cfg_rvalid, cfg_err;
    logic        eng_gnt, eng_rvalid, eng_err;
    logic [31:0] cfg_rdata, eng_rdata;
    logic [3:0]  bram_WE;
    logic        bram_EN;
    logic [31:0] bram_Di, bram_Do;
    logic [11:0] bram_A;

    int checks = 0;
    int errors = 0;

    tap_bram_arbiter #(.ADDR_WIDTH(12), .BIT_WIDTH(32), .DEPTH(11)) dut (
        .CLK(CLK), .RST(RST),
        .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata), .eng_err(eng_err),
        .eng_busy(eng_busy),
        .bram_WE(bram_WE), .bram_EN(bram_EN), .bram_Di(bram_Di), .bram_A(bram_A),
        .bram_Do(bram_Do)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // Tap RAM model
    logic [31:0] mem [0:1023];
    logic [9:0]  a_q;
    logic        preload;

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            a_q <= 10'd0;
        end else if (bram_EN) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_WE[b]) mem[bram_A[11:2]][8*b +: 8] <= bram_Di[8*b +: 8];
            end
            a_q <= bram_A[11:2];
        end
    end

    assign bram_Do = bram_EN ? mem[a_q] : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        cfg_req = 1'b0; cfg_we = 4'd0; cfg_addr = 12'd0; cfg_wdata = 32'd0;
        eng_req = 1'b0; eng_we = 4'd0; eng_addr = 12'd0; eng_wdata = 32'd0;
    endtask

    // One isolated transaction, checked at N, N+1 and N+2
    task automatic txn(input bit is_eng, input logic [3:0] we, input logic [11:0] addr,
                       input logic [31:0] wd, input bit oor, input logic [31:0] exp_rd);
        bit rd;
        rd = (we == 4'd0);
        if (is_eng) begin
            eng_req = 1'b1; eng_we = we; eng_addr = addr; eng_wdata = wd;
        end else begin
            cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
        end
        @(negedge CLK);
        check("txn_gnt", 32'(is_eng ? eng_gnt : cfg_gnt), 32'd1);
        check("txn_en_n", 32'(bram_EN), 32'(!oor));
        if (!oor) check("txn_we_n", 32'(bram_WE), 32'(we));
        tick;
        idle_inputs();
        @(negedge CLK);
        check("txn_en_n1", 32'(bram_EN), 32'(rd && !oor));
        check("txn_err_n1", 32'(is_eng ? eng_err : cfg_err), 32'd0);
        tick;
        @(negedge CLK);
        check("txn_rvalid_n2", 32'(is_eng ? eng_rvalid : cfg_rvalid), 32'(rd));
        check("txn_err_n2", 32'(is_eng ? eng_err : cfg_err), 32'(oor));
        if (rd) check("txn_rdata_n2", is_eng ? eng_rdata : cfg_rdata, exp_rd);
        tick;
        check("txn_rvalid_n3", 32'(is_eng ? eng_rvalid : cfg_rvalid), 32'd0);
    endtask

    initial begin
        idle_inputs();
        eng_busy = 1'b0;
        preload  = 1'b1;
        RST      = 1'b1;
        // Reset: requests asserted but nothing may be granted or driven
        cfg_req = 1'b1; eng_req = 1'b1; cfg_addr = 12'h004; eng_addr = 12'h014;
        tick;
        tick;
        @(negedge CLK);
        check("rst_cfg_gnt", 32'(cfg_gnt), 32'd0);
        check("rst_eng_gnt", 32'(eng_gnt), 32'd0);
        check("rst_bram_en", 32'(bram_EN), 32'd0);
        check("rst_bram_a", 32'(bram_A), 32'd0);
        check("rst_cfg_rdata", cfg_rdata, 32'd0);
        tick;
        RST = 1'b0;
        preload = 1'b0;

        // Both requesters read every cycle: cfg wins the first tie, then alternation
        for (int k = 0; k < 8; k++) begin
            cfg_req  = (k < 6);
            eng_req  = (k < 6);
            cfg_we   = 4'd0;
            eng_we   = 4'd0;
            cfg_addr = 12'(((k + 1) / 2) * 4);
            eng_addr = 12'((5 + k / 2) * 4);
            @(negedge CLK);
            if (k < 6) begin
                check("rr_cfg_gnt", 32'(cfg_gnt), 32'((k % 2) == 0));
                check("rr_eng_gnt", 32'(eng_gnt), 32'((k % 2) == 1));
            end
            if (k >= 2) begin
                check("rr_cfg_rvalid", 32'(cfg_rvalid), 32'(((k - 2) % 2) == 0));
                check("rr_eng_rvalid", 32'(eng_rvalid), 32'(((k - 2) % 2) == 1));
                if (((k - 2) % 2) == 0) check("rr_cfg_rdata", cfg_rdata, init_word((k - 2) / 2));
                else check("rr_eng_rdata", eng_rdata, init_word(5 + (k - 2) / 2));
            end
            tick;
        end
        idle_inputs();

        // Full-word write then readback
        txn(1'b0, 4'hF, 12'h008, 32'h1234_5678, 1'b0, 32'h0);
        txn(1'b0, 4'h0, 12'h008, 32'h0, 1'b0, 32'h1234_5678);

        // Config write held off while the engine is busy
        eng_busy = 1'b1;
        cfg_req = 1'b1; cfg_we = 4'hF; cfg_addr = 12'h010; cfg_wdata = 32'hCAFE_F00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("busy_no_gnt", 32'(cfg_gnt), 32'd0);
            check("busy_no_en", 32'(bram_EN), 32'd0);
            tick;
        end
        check("busy_ram_kept", mem[4], init_word(4));
        eng_busy = 1'b0;
        @(negedge CLK);
        check("busy_release_gnt", 32'(cfg_gnt), 32'd1);
        tick;
        idle_inputs();
        eng_busy = 1'b1;
        tick;
        txn(1'b0, 4'h0, 12'h010, 32'h0, 1'b0, 32'hCAFE_F00D);
        eng_busy = 1'b0;

        // Out-of-range: word 11, misaligned, engine write beyond depth
        txn(1'b0, 4'h0, 12'h02C, 32'h0, 1'b1, 32'h0);
        txn(1'b0, 4'h0, 12'h006, 32'h0, 1'b1, 32'h0);
        txn(1'b1, 4'hF, 12'h030, 32'hDEAD_BEEF, 1'b1, 32'h0);
        check("oor_ram_kept", mem[12], init_word(12));
        check("oor_eng_no_rvalid", 32'(eng_rvalid), 32'd0);

        // Byte-lane write
        txn(1'b1, 4'hF, 12'h00C, 32'h1111_1111, 1'b0, 32'h0);
        txn(1'b1, 4'b0010, 12'h00C, 32'hAABB_CCDD, 1'b0, 32'h0);
        txn(1'b1, 4'h0, 12'h00C, 32'h0, 1'b0, 32'h1111_CC11);

        // Reset one cycle after a read grant discards the read
        cfg_req = 1'b1; cfg_we = 4'h0; cfg_addr = 12'h010;
        @(negedge CLK);
        check("rstrd_gnt", 32'(cfg_gnt), 32'd1);
        tick;
        RST = 1'b1;
        @(negedge CLK);
        check("rstrd_cfg_gnt", 32'(cfg_gnt), 32'd0);
        check("rstrd_bram_en", 32'(bram_EN), 32'd0);
        check("rstrd_bram_we", 32'(bram_WE), 32'd0);
        check("rstrd_bram_a", 32'(bram_A), 32'd0);
        check("rstrd_bram_di", bram_Di, 32'd0);
        check("rstrd_rvalid", 32'(cfg_rvalid), 32'd0);
        check("rstrd_rdata", cfg_rdata, 32'd0);
        check("rstrd_err", 32'(cfg_err), 32'd0);
        tick;
        RST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        check("rstrd_n2_rvalid", 32'(cfg_rvalid), 32'd0);
        check("rstrd_n2_err", 32'(cfg_err), 32'd0);
        check("rstrd_n2_rdata", cfg_rdata, 32'd0);
        tick;
        @(negedge CLK);
        check("rstrd_n3_rvalid", 32'(cfg_rvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tap_bram_arbiter.md
TAP_BRAM_ARBITER -- requirements
Module: tap_bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address width.
REQ-002 SHALL have parameter BIT_WIDTH, default 32, data width.
REQ-003 SHALL have parameter DEPTH, default 11, number of valid 32-bit words.
REQ-004 SHALL have port CLK  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports cfg_req in 1, cfg_we in 4, cfg_addr in ADDR_WIDTH, cfg_wdata in BIT_WIDTH: config requester command; cfg_we==0 means read.
REQ-007 SHALL have ports cfg_gnt out 1, cfg_rvalid out 1, cfg_rdata out BIT_WIDTH, cfg_err out 1: config requester response.
REQ-008 SHALL have ports eng_req, eng_we, eng_addr, eng_wdata, eng_gnt, eng_rvalid, eng_rdata, eng_err: FIR-engine requester, same widths and meaning as cfg_*.
REQ-009 SHALL have port eng_busy  in  1  engine running; blocks config writes.
REQ-010 SHALL have ports bram_WE out 4, bram_EN out 1, bram_Di out BIT_WIDTH, bram_A out ADDR_WIDTH, bram_Do in BIT_WIDTH: single tap-RAM port (address registered in RAM, Do gated by current EN).

Function
REQ-011 Requester SHALL hold req/we/addr/wdata stable until gnt; gnt SHALL be a combinational one-cycle pulse in the cycle (N) the command is issued.
REQ-012 At most one gnt per cycle; only one BRAM command per cycle.
REQ-013 Eligible: eng_req; cfg_req unless (cfg_we!=0 and eng_busy). Ineligible cfg write SHALL wait without gnt.
REQ-014 Single eligible requester SHALL be granted immediately; both eligible: round-robin, requester not granted most recently wins; last_gnt register updated on every gnt.
REQ-015 In-range: addr[1:0]==0 and addr[ADDR_WIDTH-1:2] < DEPTH; otherwise out-of-range.
REQ-016 In-range grant in cycle N SHALL drive bram_A=addr, bram_WE=we, bram_Di=wdata, bram_EN=1 combinationally in cycle N.
REQ-017 In-range read granted in N SHALL force bram_EN=1 in N+1 (Do gating), with bram_WE=0 unless a new write is granted in N+1.
REQ-018 Idle cycles (no grant, no pending read) SHALL drive bram_EN=0, bram_WE=0, bram_A=0, bram_Di=0.
REQ-019 Read in cycle N: bram_Do captured at end of N+1 into owner's rdata register; owner's rvalid=1 for exactly cycle N+2; rdata held until that owner's next read completion.
REQ-020 Back-to-back reads (any requester mix) SHALL be pipelined at one per cycle, each returned to its own requester in order.
REQ-021 Out-of-range grant SHALL drive no BRAM access (EN=0, WE=0 from it); for reads owner sees rvalid=1, rdata=0, err=1 in N+2; for writes err=1 in N+2, no rvalid, no write.
REQ-022 err SHALL be 0 whenever no error response is due.
REQ-023 Writes SHALL produce no response other than gnt; byte enables pass through unchanged.

Reset
REQ-024 While RST=1: all gnt, rvalid, err = 0; rdata = 0; bram_EN=0, bram_WE=0, bram_A=0, bram_Di=0; last_gnt = eng (cfg wins first tie).
REQ-025 Reads pending when RST asserts SHALL be discarded; no rvalid/err after reset from them.

Verification
REQ-026 cfg write we=4'hF addr 0x008 data 0x1234_5678, then cfg read 0x008 -> gnt at N, bram_EN high N and N+1, cfg_rvalid at N+2, cfg_rdata=0x1234_5678.
REQ-027 Both requesters read every cycle for 6 cycles after reset -> grants alternate cfg,eng,cfg,...; each rvalid exactly 2 cycles after its gnt with correct word.
REQ-028 eng_busy=1, cfg write pending 5 cycles -> no cfg_gnt, RAM unchanged; eng_busy falls -> cfg_gnt same cycle; cfg read while busy granted normally.
REQ-029 cfg read addr 0x02C (word 11) and 0x006 (misaligned) -> no BRAM EN, cfg_rvalid=1, cfg_rdata=0, cfg_err=1 at N+2; eng write 0x030 -> eng_err at N+2, RAM untouched.
REQ-030 Byte write we=4'b0010 data 0xAABB_CCDD to word holding 0x1111_1111 -> readback 0x1111_CC11.
REQ-031 RST asserted in cycle N+1 after read grant -> no rvalid in N+2; all outputs zero during reset.
